// File: rtl/shift_pkg.sv
// Shift-mode encoding shared by the pipelined barrel shifter and its stages.
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SLL = 2'b00;
    localparam mode_t MODE_SRL = 2'b01;
    localparam mode_t MODE_SRA = 2'b10;
    localparam mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_pipe_stage.sv
// One level of the barrel shifter: conditional shift/rotate by 2^LEVEL, then
// the stage register with its valid bit and local ready term.
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int LEVEL   = 0,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_mode,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_ready_dn,
    output logic               o_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [SHAMT_W-1:0] o_shamt,
    output logic [1:0]         o_mode,
    output logic [TAG_W-1:0]   o_tag
);

    localparam int DIST = 1 << LEVEL;

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic [1:0]         r_mode;
    logic [TAG_W-1:0]   r_tag;
    logic [WIDTH-1:0]   w_shifted;

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       mode);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_SLL: r = d << DIST;
            MODE_SRL: r = d >> DIST;
            MODE_SRA: r = $signed(d) >>> DIST;
            default:  r = (d >> DIST) | (d << (WIDTH - DIST));
        endcase
        return r;
    endfunction

    // SRA fills from this stage's own MSB, which still carries the original sign.
    assign w_shifted = i_shamt[LEVEL] ? shift_level(i_data, i_mode) : i_data;

    // An empty stage accepts even while everything downstream is stalled.
    assign o_ready = !r_valid || i_ready_dn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_mode  <= '0;
            r_tag   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            r_data  <= w_shifted;
            r_shamt <= i_shamt;
            r_mode  <= i_mode;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_mode  = r_mode;
    assign o_tag   = r_tag;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register per shift level, valid/ready on both
// sides with bubble collapse, tag passthrough and synchronous flush.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int L = SHAMT_W;

    logic [L-1:0]       w_vld;
    logic [L-1:0]       w_rdy;
    logic [L-1:0]       w_rdy_dn;
    logic               w_accept;
    logic [WIDTH-1:0]   w_data  [0:L];
    logic [SHAMT_W-1:0] w_shamt [0:L];
    logic [1:0]         w_mode  [0:L];
    logic [TAG_W-1:0]   w_tag   [0:L];
    logic               w_unused;

    assign in_ready   = w_rdy[0] && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_data[0]  = data_operandA;
    assign w_shamt[0] = ctrl_shiftamt;
    assign w_mode[0]  = ctrl_mode;
    assign w_tag[0]   = in_tag;

    // Downstream ready per stage, unrolled from the output so the chain stays
    // a single combinational path from out_ready with no feedback through w_rdy.
    always_comb begin
        w_rdy_dn        = '0;
        w_rdy_dn[L-1]   = out_ready;
        for (int k = L - 2; k >= 0; k--) begin
            w_rdy_dn[k] = w_rdy_dn[k+1] || !w_vld[k+1];
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic w_vin;
        if (k == 0) begin : g_head
            assign w_vin = w_accept;
        end else begin : g_body
            assign w_vin = w_vld[k-1];
        end

        shift_pipe_stage #(
            .WIDTH   (WIDTH),
            .TAG_W   (TAG_W),
            .LEVEL   (k),
            .SHAMT_W (SHAMT_W)
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .i_valid    (w_vin),
            .i_data     (w_data[k]),
            .i_shamt    (w_shamt[k]),
            .i_mode     (w_mode[k]),
            .i_tag      (w_tag[k]),
            .i_ready_dn (w_rdy_dn[k]),
            .o_ready    (w_rdy[k]),
            .o_valid    (w_vld[k]),
            .o_data     (w_data[k+1]),
            .o_shamt    (w_shamt[k+1]),
            .o_mode     (w_mode[k+1]),
            .o_tag      (w_tag[k+1])
        );
    end

    assign out_valid   = w_vld[L-1];
    assign data_result = w_data[L];
    assign out_tag     = w_tag[L];

    // Only stage 0's ready is consumed; the last stage's shamt/mode go nowhere.
    assign w_unused = ^{w_rdy, w_shamt[L], w_mode[L]};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed vectors at WIDTH=32, 8 and 2.
`timescale 1ns/1ps
module tb_shift_pipe;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    logic        clock;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] data_operandA, data_result;
    logic [4:0]  ctrl_shiftamt;
    logic [1:0]  ctrl_mode;
    logic [3:0]  in_tag, out_tag;

    logic       v8, rdy8, ov8;
    logic [7:0] d8, res8;
    logic [2:0] a8;
    logic [1:0] m8;
    logic [3:0] t8, ot8;

    logic       v2, rdy2, ov2;
    logic [1:0] d2, res2;
    logic       a2;
    logic [1:0] m2;
    logic [3:0] t2, ot2;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t q2[$];

    logic [31:0] v_op   [16] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'h12345678,
                                 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F,
                                 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h0000FFFF,
                                 32'hFFFFFFFF, 32'hF000000F, 32'h80000001, 32'h12345678};
    logic [4:0]  v_amt  [16] = '{5'd4, 5'd4, 5'd31, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0,
                                 5'd31, 5'd1, 5'd31, 5'd16, 5'd31, 5'd4, 5'd5, 5'd4};
    logic [1:0]  v_mode [16] = '{MODE_SRA, MODE_SRL, MODE_SLL, MODE_ROR,
                                 MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR,
                                 MODE_SRA, MODE_SRA, MODE_ROR, MODE_SLL,
                                 MODE_SRL, MODE_ROR, MODE_SRA, MODE_SLL};
    logic [31:0] v_exp  [16] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h78123456,
                                 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F,
                                 32'h00000000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFF0000,
                                 32'h00000001, 32'hFF000000, 32'hFC000000, 32'h23456780};

    logic [7:0] s8_op   [4] = '{8'h90, 8'h81, 8'h0F, 8'hF0};
    logic [2:0] s8_amt  [4] = '{3'd3, 3'd1, 3'd4, 3'd7};
    logic [1:0] s8_mode [4] = '{MODE_SRA, MODE_ROR, MODE_SLL, MODE_SRL};
    logic [7:0] s8_exp  [4] = '{8'hF2, 8'hC0, 8'hF0, 8'h01};

    logic [1:0] s2_op   [4] = '{2'b10, 2'b01, 2'b10, 2'b10};
    logic       s2_amt  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] s2_mode [4] = '{MODE_ROR, MODE_SLL, MODE_SRA, MODE_SRL};
    logic [1:0] s2_exp  [4] = '{2'b01, 2'b10, 2'b11, 2'b10};

    shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .ctrl_shiftamt(ctrl_shiftamt),
        .ctrl_mode(ctrl_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .out_tag(out_tag)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clock(clock), .reset(reset), .flush(1'b0),
        .in_valid(v8), .in_ready(rdy8),
        .data_operandA(d8), .ctrl_shiftamt(a8), .ctrl_mode(m8), .in_tag(t8),
        .out_valid(ov8), .out_ready(1'b1), .data_result(res8), .out_tag(ot8)
    );

    shift_pipe #(.WIDTH(2), .TAG_W(4)) dut2 (
        .clock(clock), .reset(reset), .flush(1'b0),
        .in_valid(v2), .in_ready(rdy2),
        .data_operandA(d2), .ctrl_shiftamt(a2), .ctrl_mode(m2), .in_tag(t2),
        .out_valid(ov2), .out_ready(1'b1), .data_result(res2), .out_tag(ot2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Called on the falling edge before the accepting rising edge.
    task automatic push32(input int idx, input logic [3:0] tag, input int lat);
        exp_t e;
        e.data = v_exp[idx % 16];
        e.tag  = tag;
        e.acc  = cyc + 1;
        e.lat  = lat;
        q32.push_back(e);
    endtask

    task automatic drive32(input int idx);
        in_valid      = 1'b1;
        data_operandA = v_op[idx % 16];
        ctrl_shiftamt = v_amt[idx % 16];
        ctrl_mode     = v_mode[idx % 16];
        in_tag        = 4'(idx);
    endtask

    task automatic send32(input int idx, input bit push, input int lat, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        drive32(idx);
        while (!acc && waits < 40) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1'b1;
                if (push) push32(idx, 4'(idx), lat);
            end else begin
                waits++;
            end
            @(posedge clock); #1;
        end
        if (!acc) fail_now("w32_accept_timeout", "in_ready never rose within 40 cycles");
        in_valid = 1'b0;
    endtask

    // Keeps offering consecutive ops; leaves the next unaccepted one held on the input.
    task automatic offer_stream(input int ncyc, input int first, output int nacc, output int nxt);
        bit acc;
        nacc = 0;
        nxt  = first;
        for (int i = 0; i < ncyc; i++) begin
            drive32(nxt);
            @(negedge clock);
            acc = in_ready;
            if (acc) begin
                push32(nxt, 4'(nxt), -1);
                nacc++;
            end
            @(posedge clock); #1;
            if (acc) nxt++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0 || q2.size() != 0) && n < 60) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (n >= 60) fail_now("drain_timeout", "expected results still pending after 60 cycles");
    endtask

    task automatic release_drain(input int nxt);
        out_ready = 1'b1;
        @(negedge clock);
        check("release_in_ready_same_cycle", 32'(in_ready), 32'd1);
        if (in_ready) push32(nxt, 4'(nxt), -1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic send8(input int i);
        exp_t e;
        v8 = 1'b1; d8 = s8_op[i]; a8 = s8_amt[i]; m8 = s8_mode[i]; t8 = 4'(i + 8);
        @(negedge clock);
        check("w8_in_ready", 32'(rdy8), 32'd1);
        if (rdy8) begin
            e.data = 32'(s8_exp[i]); e.tag = t8; e.acc = cyc + 1; e.lat = 3;
            q8.push_back(e);
        end
        @(posedge clock); #1;
        v8 = 1'b0;
    endtask

    task automatic send2(input int i);
        exp_t e;
        v2 = 1'b1; d2 = s2_op[i]; a2 = s2_amt[i]; m2 = s2_mode[i]; t2 = 4'(i + 12);
        @(negedge clock);
        check("w2_in_ready", 32'(rdy2), 32'd1);
        if (rdy2) begin
            e.data = 32'(s2_exp[i]); e.tag = t2; e.acc = cyc + 1; e.lat = 1;
            q2.push_back(e);
        end
        @(posedge clock); #1;
        v2 = 1'b0;
    endtask

    always @(negedge clock) begin : mon32
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                fail_now("w32_unexpected_output", $sformatf("got out_valid=1 tag=%0d, required no output", out_tag));
            end else begin
                e = q32.pop_front();
                check("w32_data", data_result, e.data);
                check("w32_tag", 32'(out_tag), 32'(e.tag));
                if (e.lat >= 0) check("w32_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp_t e;
        if (!reset && ov8) begin
            if (q8.size() == 0) begin
                fail_now("w8_unexpected_output", "got out_valid=1, required no output");
            end else begin
                e = q8.pop_front();
                check("w8_data", 32'(res8), e.data);
                check("w8_tag", 32'(ot8), 32'(e.tag));
                check("w8_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            end
        end
    end

    always @(negedge clock) begin : mon2
        exp_t e;
        if (!reset && ov2) begin
            if (q2.size() == 0) begin
                fail_now("w2_unexpected_output", "got out_valid=1, required no output");
            end else begin
                e = q2.pop_front();
                check("w2_data", 32'(res2), e.data);
                check("w2_tag", 32'(ot2), 32'(e.tag));
                check("w2_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        int          w, nacc, nxt;
        logic [31:0] held;
        logic [3:0]  held_tag;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_operandA = '0; ctrl_shiftamt = '0; ctrl_mode = '0; in_tag = '0;
        v8 = 1'b0; d8 = '0; a8 = '0; m8 = '0; t8 = '0;
        v2 = 1'b0; d2 = '0; a2 = 1'b0; m2 = '0; t2 = '0;

        @(negedge clock);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_data_result", data_result, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_w8_out_valid", 32'(ov8), 32'd0);
        check("reset_w2_out_valid", 32'(ov2), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;

        // Isolated op, then every table vector back to back at full rate.
        send32(3, 1'b1, 5, w);
        wait_drain();
        for (int i = 0; i < 16; i++) begin
            send32(i, 1'b1, 5, w);
            check("throughput_no_stall", 32'(w), 32'd0);
        end
        wait_drain();

        for (int i = 0; i < 4; i++) send8(i);
        for (int i = 0; i < 4; i++) send2(i);
        wait_drain();

        // Backpressure: exactly five fit, head result holds steady.
        out_ready = 1'b0;
        offer_stream(10, 0, nacc, nxt);
        check("bp_accepted", 32'(nacc), 32'd5);
        @(negedge clock);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_data", data_result, v_exp[0]);
        held     = data_result;
        held_tag = out_tag;
        repeat (3) begin
            @(negedge clock);
            check("bp_result_stable", data_result, held);
            check("bp_tag_stable", 32'(out_tag), 32'(held_tag));
        end
        @(posedge clock); #1;
        release_drain(nxt);

        // Bubble collapse: A, two idle cycles, B, then fill the rest.
        out_ready = 1'b0;
        send32(0, 1'b1, -1, w);
        repeat (2) @(posedge clock);
        #1;
        send32(1, 1'b1, -1, w);
        check("bubble_B_accepted_at_once", 32'(w), 32'd0);
        offer_stream(8, 2, nacc, nxt);
        check("bubble_extra_accepts", 32'(nacc), 32'd3);
        @(negedge clock);
        check("bubble_full_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        release_drain(nxt);

        // Flush with three ops in flight.
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) send32(i, 1'b0, -1, w);
        flush = 1'b1;
        drive32(6);
        @(negedge clock);
        check("flush_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            check("flush_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clock); #1;

        // Asynchronous reset between edges with a full, stalled pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive32(13 + i);
            in_tag = 4'(9 + i);
            @(negedge clock);
            check("rst_fill_in_ready", 32'(in_ready), 32'd1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("rst_pre_out_valid", 32'(out_valid), 32'd1);
        check("rst_pre_data", data_result, v_exp[13]);
        check("rst_pre_tag", 32'(out_tag), 32'd9);
        #2 reset = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        check("rst_async_data", data_result, 32'd0);
        check("rst_async_tag", 32'(out_tag), 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #3;
        reset = 1'b0;
        @(negedge clock);
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("rst_no_stale_output", 32'(out_valid), 32'd0);
        end
        @(posedge clock); #1;

        send32(10, 1'b1, 5, w);
        send32(14, 1'b1, 5, w);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
